// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU.
// One 32-bit add per cycle: the partial-product high word plus the multiplicand
// (when the current multiplier bit is set). The operation runs on operand magnitudes,
// and the sign is applied in a final fix-up cycle.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   result;

  // Magnitude of a two's-complement operand; the most negative value maps to
  // itself, which is the correct magnitude once read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x,
                                               input logic sgn);
    logic signed [WIDTH-1:0] m;
    m = (sgn && (x < 0)) ? -x : x;
    return m;
  endfunction

  // Two's-complement negation of the full-width product.
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // One iteration's add: high word plus the gated multiplicand, carry kept as bit WIDTH.
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};

  // Sign fix-up applied only on the final cycle.
  assign result = neg ? negate(p) : p;

  // Control FSM together with the operand, partial-product and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= abs_val(a, is_signed);
            mplier <= abs_val(b, is_signed);
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            p      <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          p      <= {sum, p[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases, handshake and reset
// boundaries, then randomized operands against a plain-arithmetic product model.
module tb_mult_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    longint sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current (negedge) time; the next posedge accepts it.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    start     = 1'b1;
    a         = x;
    b         = y;
    is_signed = s;
  endtask

  // Follow an accepted operation to its done pulse and check timing and result.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int ign_at);
    int n;
    int busy_cnt;
    bit hold_ok;
    bit got;
    n = 0; busy_cnt = 0; hold_ok = 1'b1; got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (ign_at != 0 && n == ign_at) begin
        start     = 1'b1;
        a         = 32'd1;
        b         = 32'd1;
        is_signed = 1'($urandom_range(0, 1));
      end else begin
        start     = 1'b0;
        a         = $urandom();
        b         = $urandom();
        is_signed = 1'($urandom_range(0, 1));
      end
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd34);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, " hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " result"}, {hi, lo}, exp);
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          no_done;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(32'd3, 32'd5, 1'b0);
    wait_done("u3x5", 64'h00000000_0000000F, 0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done("umax", 64'hFFFFFFFE_00000001, 0);
    start_op(32'hFFFFFFFF, 32'h00000002, 1'b1);
    wait_done("s_m1x2", 64'hFFFFFFFF_FFFFFFFE, 0);
    start_op(32'hFFFFFFFF, 32'h00000002, 1'b0);
    wait_done("u_m1x2", 64'h00000001_FFFFFFFE, 0);
    start_op(32'h80000000, 32'h80000000, 1'b1);
    wait_done("s_minxmin", 64'h40000000_00000000, 0);

    // Start pulsed mid-operation must be ignored; next start lands in the done cycle.
    start_op(32'd7, 32'd9, 1'b0);
    wait_done("ignore_start", 64'd63, 10);
    start_op(32'd2, 32'd2, 1'b0);
    wait_done("b2b", 64'd4, 0);

    // Reset in the middle of an operation.
    start_op(32'h1234, 32'h10, 1'b0);
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hilo", {hi, lo}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("midrst no_done", 64'(no_done), 64'd1);
    start_op(32'd6, 32'd7, 1'b0);
    wait_done("after_rst", 64'd42, 0);

    // Randomized operands with occasional idle gaps.
    for (int i = 0; i < 25; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 1) ra = 32'h0;
      if (i % 7 == 2) rb = 32'h80000000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(ra, rb, rs);
      wait_done($sformatf("rand%0d", i), ref_prod(ra, rb, rs), 0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier for the MIPS MULT/MULTU instructions.
- Sits downstream of the 32-bit ripple/prefix adder (add32): each iteration drives one 32-bit add of the partial-product high word plus the multiplicand.
- Produces the 64-bit HI/LO pair consumed by the HI/LO register file / MFHI/MFLO path.
- Multi-cycle, with a start/busy/done handshake toward the pipeline stall logic.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is required to be supported; other values are untested.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  single-cycle pulse when hi/lo are updated
hi  output  WIDTH  upper product word
lo  output  WIDTH  lower product word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, iteration counter=0.
  - busy=0, done=0, hi=0, lo=0, all internal product/operand registers=0.
  - Release is synchronous to the next clk edge.
- States: IDLE -> CALC -> FIX -> IDLE. Edge numbering below is relative to the start-accept edge (edge 0).
- Edge 0, IDLE with start=1:
  - Latch mcand=|a|, mplier=|b| (absolute values only if is_signed, else raw).
  - Latch neg = is_signed & (a[31]^b[31]).
  - Clear partial product P (64b) and counter.
  - Go to CALC; busy=1 from the following cycle.
- CALC, edges 1..32, one iteration per edge:
  - sum[32:0] = P[63:32] + (mplier[0] ? mcand : 0), computed as a 33-bit unsigned add with cin=0.
  - P <= {sum, P[31:1]}; mplier >>= 1; counter++.
  - After the 32nd iteration (edge 32) go to FIX.
- FIX, edge 33:
  - If neg, result = (~P)+1 over 64 bits; else result = P.
  - hi <= result[63:32], lo <= result[31:0].
  - done=1 for exactly one cycle; busy=0 in that same cycle; state=IDLE.
- Latency: start high at edge 0 -> done high in the cycle after edge 33 (34 cycles). busy is high for 33 cycles.
- hi/lo hold their previous result throughout CALC/FIX; they change only on the FIX edge.
- Handshake and reset boundaries:
  - start while busy=1: ignored, with no effect on the operation in flight.
  - start in the done cycle: accepted, since the state is IDLE; back-to-back operations are allowed.
  - Reset mid-operation aborts: the operation is discarded, hi/lo=0, done is never asserted for it.
  - The operand inputs a, b, is_signed are don't-care outside the accept edge.
- Arithmetic and width:
  - |x| of 0x80000000 is 0x80000000, interpreted unsigned.
  - The product never overflows 64 bits.
  - Zero operands still take the full 34 cycles; there is no early termination.

Test Plan:
- Unsigned: start, is_signed=0, a=3, b=5 -> done exactly 34 cycles after start; hi=0x00000000, lo=0x0000000F.
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed: a=0xFFFFFFFF (-1), b=0x00000002, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with is_signed=0 -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed corner: a=b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000.
- Handshake:
  - Pulse start again at cycle 10 of an op (a=7, b=9) with a=1, b=1 -> ignored; result hi=0, lo=63.
  - Assert start with a=2, b=2 in the done cycle -> second done 34 cycles later with lo=4.
- Reset mid-op: rst_n low at cycle 15 of a=0x1234, b=0x10 -> busy=0, done=0, hi=lo=0 immediately; no done pulse. Next op a=6, b=7 -> lo=42.
- Randomized: random 32-bit a, b, is_signed -> every done matches the 64-bit reference product (signed or unsigned).
